// File: rtl/axi_rd_slv_pkg.sv
// Shared types and constants for the AXI4 read-only memory slave.
// Holds the AR queue entry layout and the per-beat data/response helper.
package axi_rd_slv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [2:0]  SIZE_4B  = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_entry_t;

    localparam int unsigned AR_ENTRY_W = $bits(ar_entry_t);

    // Returns {resp, data} for one beat; the window test uses a wrapping offset.
    function automatic logic [33:0] beat_word(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [31:0] bytes,
                                              input logic [31:0] seed,
                                              input logic        err);
        logic [31:0] off;
        off = addr - base;
        if (err || (off >= bytes)) begin
            return {RESP_SLVERR, ERR_DATA};
        end
        return {RESP_OKAY, seed + (off >> 2)};
    endfunction

endpackage

// File: rtl/axi_rd_slv_ar_fifo.sv
// Synchronous FIFO of AR entries with async active-high reset.
// full_next_o reports occupancy after the current edge, for a registered ready.
module axi_rd_slv_ar_fifo
    import axi_rd_slv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  ar_entry_t wdata_i,
    input  logic      pop_i,
    output ar_entry_t rdata_o,
    output logic      empty_o,
    output logic      full_next_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [AR_ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  full, do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (DEPTH == 1) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full        = (cnt_q == CntW'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign do_pop      = pop_i && !empty_o;
    // A push while full is legal only when the head leaves in the same cycle.
    assign do_push     = push_i && (!full || do_pop);
    assign full_next_o = (cnt_d == CntW'(DEPTH));
    assign rdata_o     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_mm2s_rd_slave.sv
// AXI4 read-only slave returning address-derived data with exact RLAST framing.
// Optional RD_SLV_THROTTLE_EN inserts one idle cycle after every THROTTLE_PERIOD beats.
module axi_mm2s_rd_slave
    import axi_rd_slv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES       = 32'h0001_0000,
    parameter logic [31:0] DATA_SEED       = 32'h5A5A_0000,
    parameter int unsigned AR_FIFO_DEPTH   = 2,
    parameter int unsigned THROTTLE_PERIOD = 4
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [7:0]  beats_left_q, beats_left_d;
    logic        err_q, err_d, fixed_q, fixed_d;
    logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        arready_q;

    ar_entry_t   ar_in, ar_head;
    logic        push, pop, fifo_empty, fifo_full_next;
    logic        beat_fire, load, adv;

    logic [6:0]  unused_ar_attr;
    assign unused_ar_attr = {S_AXI_ARCACHE, S_AXI_ARPROT};

    assign ar_in = '{addr: S_AXI_ARADDR, len: S_AXI_ARLEN, size: S_AXI_ARSIZE,
                     burst: S_AXI_ARBURST};
    assign push  = S_AXI_ARVALID && arready_q;

    axi_rd_slv_ar_fifo #(
        .DEPTH (AR_FIFO_DEPTH)
    ) u_ar_fifo (
        .clk_i       (S_AXI_ACLK),
        .rst_i       (S_AXI_ARESET),
        .push_i      (push),
        .wdata_i     (ar_in),
        .pop_i       (pop),
        .rdata_o     (ar_head),
        .empty_o     (fifo_empty),
        .full_next_o (fifo_full_next)
    );

`ifdef RD_SLV_THROTTLE_EN
    logic [31:0] thr_cnt_q;
    logic        gap_q;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            thr_cnt_q <= '0;
            gap_q     <= 1'b0;
        end else begin
            gap_q <= 1'b0;
            if (beat_fire) begin
                if (thr_cnt_q == 32'(THROTTLE_PERIOD - 1)) begin
                    thr_cnt_q <= '0;
                    gap_q     <= 1'b1;
                end else begin
                    thr_cnt_q <= thr_cnt_q + 32'd1;
                end
            end
        end
    end

    // The pending beat stays in the output registers; only its valid is masked.
    assign S_AXI_RVALID = rvalid_q && !gap_q;
`else
    logic [31:0] unused_thr_period;
    assign unused_thr_period = 32'(THROTTLE_PERIOD);
    assign S_AXI_RVALID      = rvalid_q;
`endif

    assign beat_fire     = S_AXI_RVALID && S_AXI_RREADY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        err_d        = err_q;
        fixed_d      = fixed_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        pop          = 1'b0;
        load         = 1'b0;
        adv          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            StBurst: begin
                if (beat_fire) begin
                    if (beats_left_q == 8'd0) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d  = StIdle;
                            rvalid_d = 1'b0;
                            rlast_d  = 1'b0;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            pop          = 1'b1;
            state_d      = StBurst;
            cur_addr_d   = ar_head.addr;
            beats_left_d = ar_head.len;
            err_d        = (ar_head.size != SIZE_4B) || (ar_head.burst == BURST_WRAP) ||
                           (ar_head.burst == 2'b11);
            fixed_d      = (ar_head.burst == BURST_FIXED);
            rvalid_d     = 1'b1;
            rlast_d      = (ar_head.len == 8'd0);
        end else if (adv) begin
            cur_addr_d   = fixed_q ? cur_addr_q : cur_addr_q + 32'd4;
            beats_left_d = beats_left_q - 8'd1;
            rlast_d      = (beats_left_q == 8'd1);
        end

        if (load || adv) begin
            {rresp_d, rdata_d} = beat_word(cur_addr_d, BASE_ADDR, MEM_BYTES, DATA_SEED, err_d);
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
            fixed_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            arready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            err_q        <= err_d;
            fixed_q      <= fixed_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            arready_q    <= !fifo_full_next;
        end
    end

endmodule

// File: tb/tb_axi_mm2s_rd_slave.sv
// Self-checking bench for axi_mm2s_rd_slave: a burst-level model predicts every beat,
// and directed tests pin latency, framing, back-pressure and reset behaviour.
module tb_axi_mm2s_rd_slave;

    localparam logic [31:0] M_BASE  = 32'h0000_0000;
    localparam logic [31:0] M_BYTES = 32'h0001_0000;
    localparam logic [31:0] M_SEED  = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;

    int nchk = 0;
    int npass = 0;
    int cyc = 0;

    beat_t       exp_q[$];
    logic [31:0] got_d[$];
    logic [1:0]  got_r[$];
    logic        got_l[$];
    int          got_c[$];

    logic        prev_hold = 1'b0;
    logic [31:0] prev_d;
    logic [1:0]  prev_r;
    logic        prev_l;

    always #5 clk = ~clk;

    axi_mm2s_rd_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARCACHE (4'h3),
        .S_AXI_ARPROT  (3'h0),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act === req) npass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        nchk++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Expand one AR into the beats the slave must return.
    task automatic model_push(input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] sz, input logic [1:0] bu);
        bit          bad;
        logic [31:0] ad;
        beat_t       b;
        bad = (sz != 3'b010) || (bu == 2'b10) || (bu == 2'b11);
        for (int i = 0; i <= int'(len); i++) begin
            ad = (bu == 2'b01) ? a + 32'(4 * i) : a;
            if (!bad && (ad - M_BASE) < M_BYTES) begin
                b.d = M_SEED + ((ad - M_BASE) / 4);
                b.r = 2'b00;
            end else begin
                b.d = 32'hDEAD_BEEF;
                b.r = 2'b10;
            end
            b.l = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_rvalid", rvalid, 1);
                check("hold_rdata", rdata, prev_d);
                check("hold_rresp", rresp, prev_r);
                check("hold_rlast", rlast, prev_l);
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    $display("FAIL spurious_beat: got data %0h, required no beat", rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_rdata", rdata, e.d);
                    check("beat_rresp", rresp, e.r);
                    check("beat_rlast", rlast, e.l);
                end
                got_d.push_back(rdata);
                got_r.push_back(rresp);
                got_l.push_back(rlast);
                got_c.push_back(cyc);
            end
            prev_hold = rvalid && !rready;
            prev_d    = rdata;
            prev_r    = rresp;
            prev_l    = rlast;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_r.delete();
        got_l.delete();
        got_c.delete();
    endtask

    // Caller is just after a rising edge; returns just after the handshake edge.
    task automatic ar(input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bu);
        araddr  = a;
        arlen   = len;
        arsize  = sz;
        arburst = bu;
        arvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arready) begin
                model_push(a, len, sz, bu);
                @(posedge clk);
                #1;
                arvalid = 1'b0;
                return;
            end
        end
        arvalid = 1'b0;
        fail_now("ar_handshake");
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rvalid) return;
        end
        fail_now("drain");
        exp_q.delete();
    endtask

    task automatic check_beats(input string name, input logic [31:0] d[], input logic [1:0] r[],
                               input logic l[]);
        check({name, "_count"}, got_d.size(), d.size());
        for (int i = 0; i < d.size() && i < got_d.size(); i++) begin
            check({name, "_data"}, got_d[i], d[i]);
            check({name, "_resp"}, got_r[i], r[i]);
            check({name, "_last"}, got_l[i], l[i]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        rst = 1'b0;
        @(negedge clk);
        check("arready_pre_edge", arready, 0);
        @(negedge clk);
        check("arready_first_edge", arready, 1);

        // Single INCR burst and its first-beat latency.
        sync();
        clear_log();
        ar(32'h10, 8'd3, 3'b010, 2'b01);
        @(negedge clk);
        check("t1_no_early_rvalid", rvalid, 0);
        @(negedge clk);
        check("t1_first_rvalid", rvalid, 1);
        check("t1_first_rdata", rdata, 32'h5A5A_0004);
        wait_drain(50);
        check_beats("t1", '{32'h5A5A_0004, 32'h5A5A_0005, 32'h5A5A_0006, 32'h5A5A_0007},
                    '{2'b00, 2'b00, 2'b00, 2'b00}, '{1'b0, 1'b0, 1'b0, 1'b1});

        // Back-to-back bursts stream without a bubble.
        sync();
        clear_log();
        ar(32'h0, 8'd1, 3'b010, 2'b01);
        ar(32'h100, 8'd0, 3'b010, 2'b01);
        wait_drain(50);
        check_beats("t2", '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0040},
                    '{2'b00, 2'b00, 2'b00}, '{1'b0, 1'b1, 1'b1});
`ifndef RD_SLV_THROTTLE_EN
        if (got_c.size() == 3) begin
            check("t2_contig_1", got_c[1] - got_c[0], 1);
            check("t2_contig_2", got_c[2] - got_c[1], 1);
        end
`endif

        // Queue fills under back-pressure: ARREADY must stay low.
        sync();
        clear_log();
        rready = 1'b0;
        ar(32'h0, 8'd0, 3'b010, 2'b01);
        ar(32'h4, 8'd0, 3'b010, 2'b01);
        ar(32'h8, 8'd0, 3'b010, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2b_arready_full", arready, 0);
        end
        sync();
        rready = 1'b1;
        ar(32'hC, 8'd0, 3'b010, 2'b01);
        wait_drain(50);
        check_beats("t2b", '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003},
                    '{2'b00, 2'b00, 2'b00, 2'b00}, '{1'b1, 1'b1, 1'b1, 1'b1});

        // FIXED burst with RREADY toggling.
        sync();
        clear_log();
        rready = 1'b0;
        ar(32'h20, 8'd2, 3'b010, 2'b00);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            rready = ~rready;
        end
        rready = 1'b1;
        wait_drain(50);
        check_beats("t3", '{32'h5A5A_0008, 32'h5A5A_0008, 32'h5A5A_0008},
                    '{2'b00, 2'b00, 2'b00}, '{1'b0, 1'b0, 1'b1});

        // Burst straddling the window end.
        sync();
        clear_log();
        ar(32'h0000_FFF8, 8'd3, 3'b010, 2'b01);
        wait_drain(50);
        check_beats("t4", '{32'h5A5A_3FFE, 32'h5A5A_3FFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
                    '{2'b00, 2'b00, 2'b10, 2'b10}, '{1'b0, 1'b0, 1'b0, 1'b1});

        // Unsupported size and WRAP burst type.
        sync();
        clear_log();
        ar(32'h0, 8'd1, 3'b001, 2'b01);
        ar(32'h0, 8'd1, 3'b010, 2'b10);
        wait_drain(50);
        check_beats("t5", '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
                    '{2'b10, 2'b10, 2'b10, 2'b10}, '{1'b0, 1'b1, 1'b0, 1'b1});

        // Longest burst: 256 beats.
        sync();
        clear_log();
        ar(32'h0, 8'd255, 3'b010, 2'b01);
        wait_drain(600);
        check("t6_count", got_d.size(), 256);
        if (got_d.size() == 256) begin
            check("t6_last_data", got_d[255], 32'h5A5A_00FF);
            check("t6_penult_last", got_l[254], 0);
            check("t6_final_last", got_l[255], 1);
        end

        // Reset asserted mid-burst.
        sync();
        clear_log();
        ar(32'h40, 8'd15, 3'b010, 2'b01);
        for (int i = 0; i < 50 && got_d.size() < 5; i++) @(negedge clk);
        if (got_d.size() < 5) fail_now("t7_midburst");
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_rvalid", rvalid, 0);
        check("t7_rst_arready", arready, 0);
        check("t7_rst_rlast", rlast, 0);
        check("t7_rst_rdata", rdata, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_arready_pre_edge", arready, 0);
        @(negedge clk);
        check("t7_arready_first_edge", arready, 1);

`ifdef RD_SLV_THROTTLE_EN
        sync();
        clear_log();
        ar(32'h0, 8'd7, 3'b010, 2'b01);
        wait_drain(60);
        check("thr_count", got_d.size(), 8);
        for (int i = 1; i < 8 && i < got_c.size(); i++) begin
            check("thr_gap", got_c[i] - got_c[i-1], (i == 4) ? 2 : 1);
        end
`endif

        sync();
        clear_log();
        ar(32'h8, 8'd0, 3'b010, 2'b01);
        wait_drain(50);
        check_beats("t7_after", '{32'h5A5A_0002}, '{2'b00}, '{1'b1});

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
